// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types and constants for the wait-state data memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // Wait counter width; covers Latency 0..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response channels between datapath and data memory
// master: datapath (drives req_*, rsp_ready); slave: memory responder (drives req_ready, rsp_*).
interface data_mem_responder_if #(
    parameter int Bits = 16
);
    logic            req_valid;
    logic            req_write;
    logic [Bits-1:0] req_addr;
    logic [Bits-1:0] req_wdata;
    logic            req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [Bits-1:0] rsp_rdata;
    logic            rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder_array.sv
// rtl/data_mem_responder_array.sv - word storage with synchronous write, combinational read
// Ports: clk, rst_n (async clear of all words), we/waddr/wdata (write port), raddr/rdata (read port).
module dmem_array #(
    parameter  int Bits    = 16,
    parameter  int MemSize = 8,
    localparam int AW      = (MemSize > 1) ? $clog2(MemSize) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [Bits-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [Bits-1:0] rdata
);
    logic [Bits-1:0] mem_q [MemSize];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MemSize; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Guards index values past the end when MemSize is not a power of two.
    assign rdata = (int'(raddr) < MemSize) ? mem_q[raddr] : '0;
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state load/store responder owning the data array
// Ports: clk (rising edge), rst (async, active-low), bus (slave side of data_mem_responder_if:
// request channel req_valid/req_ready/req_write/req_addr/req_wdata, response channel
// rsp_valid/rsp_ready/rsp_rdata/rsp_error).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int Bits    = 16,
    parameter int MemSize = 8,
    parameter int Latency = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int AW = (MemSize > 1) ? $clog2(MemSize) : 1;

    dmem_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [Bits-1:0] addr_q, addr_d;
    logic [Bits-1:0] wdata_q, wdata_d;
    logic [Bits-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            req_ready;
    logic            rsp_valid;

    // The access happens either on the acceptance edge (zero latency, live inputs)
    // or on the last WAIT edge (captured registers).
    logic            take_now;
    logic            acc_en;
    logic            acc_write;
    logic [Bits-1:0] acc_addr;
    logic [Bits-1:0] acc_wdata;
    logic            in_range;
    logic [Bits-1:0] mem_rdata;

    assign take_now  = (Latency == 0) && (state_q == IDLE) && bus.req_valid;
    assign acc_en    = take_now || ((state_q == WAIT) && (cnt_q == '0));
    assign acc_write = take_now ? bus.req_write : wr_q;
    assign acc_addr  = take_now ? bus.req_addr  : addr_q;
    assign acc_wdata = take_now ? bus.req_wdata : wdata_q;
    assign in_range  = acc_addr < Bits'(MemSize);

    dmem_array #(
        .Bits    (Bits),
        .MemSize (MemSize)
    ) u_array (
        .clk   (clk),
        .rst_n (rst),
        .we    (acc_en && acc_write && in_range),
        .waddr (acc_addr[AW-1:0]),
        .wdata (acc_wdata),
        .raddr (acc_addr[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (Latency == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(Latency - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stores and errors report zero data; only in-range loads return the word.
        if (acc_en) begin
            rdata_d = (in_range && !acc_write) ? mem_rdata : '0;
            err_d   = !in_range;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    logic [15:0] exp_mem [8];

    data_mem_responder_if #(.Bits(16)) b2 ();
    data_mem_responder_if #(.Bits(16)) b0 ();

    data_mem_responder #(.Bits(16), .MemSize(8), .Latency(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    data_mem_responder #(.Bits(16), .MemSize(8), .Latency(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Starts and ends just after a falling edge; returns cycles from acceptance to rsp_valid.
    task automatic issue_wait(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                              output int lat);
        b2.req_valid = 1'b1;
        b2.req_write = wr;
        b2.req_addr  = addr;
        b2.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        b2.req_valid = 1'b0;
        lat = 1;
        while (!b2.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd, output logic er);
        issue_wait(wr, addr, wd, lat);
        rd = b2.rsp_rdata;
        er = b2.rsp_error;
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        er;

        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;

        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
        b2.rsp_ready = 1'b1;
        b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
        b0.rsp_ready = 1'b1;

        // Reset then idle
        rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(b2.rsp_rdata), 32'd0);
        check("rst_rsp_error", 32'(b2.rsp_error), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(b2.req_ready), 32'd1);
        check("idle_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        access(1'b0, 16'd3, 16'h0, lat, rd, er);
        check("load3_after_reset", 32'(rd), 32'h0);

        // Store then load, Latency=2
        access(1'b1, 16'd5, 16'hBEEF, lat, rd, er);
        exp_mem[5] = 16'hBEEF;
        check("store5_latency", 32'(lat), 32'd3);
        check("store5_rdata", 32'(rd), 32'h0);
        check("store5_error", 32'(er), 32'd0);
        check("post_hs_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        check("post_hs_req_ready", 32'(b2.req_ready), 32'd1);
        access(1'b0, 16'd5, 16'h0, lat, rd, er);
        check("load5_latency", 32'(lat), 32'd3);
        check("load5_rdata", 32'(rd), 32'hBEEF);

        // Back-pressure with an ignored store attempt
        b2.rsp_ready = 1'b0;
        issue_wait(1'b0, 16'd5, 16'h0, lat);
        check("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_%0d", i), 32'(b2.rsp_valid), 32'd1);
            check($sformatf("bp_rdata_%0d", i), 32'(b2.rsp_rdata), 32'hBEEF);
            check($sformatf("bp_req_ready_%0d", i), 32'(b2.req_ready), 32'd0);
            if (i == 1) begin
                b2.req_valid = 1'b1; b2.req_write = 1'b1;
                b2.req_addr = 16'd5; b2.req_wdata = 16'h1111;
            end
            if (i == 2) b2.req_valid = 1'b0;
            @(negedge clk);
        end
        b2.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(b2.rsp_valid), 32'd0);
        check("bp_release_ready", 32'(b2.req_ready), 32'd1);
        check("bp_release_rdata", 32'(b2.rsp_rdata), 32'h0);
        access(1'b0, 16'd5, 16'h0, lat, rd, er);
        check("bp_mem5_kept", 32'(rd), 32'hBEEF);

        // Out of range
        access(1'b1, 16'd8, 16'h1234, lat, rd, er);
        check("oor_store_error", 32'(er), 32'd1);
        check("oor_store_rdata", 32'(rd), 32'h0);
        access(1'b0, 16'hFFFF, 16'h0, lat, rd, er);
        check("oor_load_error", 32'(er), 32'd1);
        check("oor_load_rdata", 32'(rd), 32'h0);
        for (int a = 0; a < 8; a++) begin
            access(1'b0, 16'(a), 16'h0, lat, rd, er);
            check($sformatf("scan_rdata_%0d", a), 32'(rd), 32'(exp_mem[a]));
            check($sformatf("scan_error_%0d", a), 32'(er), 32'd0);
        end

        // Reset while a store waits
        b2.req_valid = 1'b1; b2.req_write = 1'b1;
        b2.req_addr = 16'd2; b2.req_wdata = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        b2.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midwait_rsp_valid_a", 32'(b2.rsp_valid), 32'd0);
        @(negedge clk);
        check("midwait_rsp_valid_b", 32'(b2.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midwait_rsp_valid_c", 32'(b2.rsp_valid), 32'd0);
        access(1'b0, 16'd2, 16'h0, lat, rd, er);
        check("midwait_mem2_zero", 32'(rd), 32'h0);
        access(1'b0, 16'd5, 16'h0, lat, rd, er);
        check("reset_clears_mem5", 32'(rd), 32'h0);

        // Latency=0 instance: one-cycle response, acceptance every 2 cycles
        b0.req_valid = 1'b1; b0.req_write = 1'b1;
        b0.req_addr = 16'd1; b0.req_wdata = 16'h00A5;
        @(posedge clk);
        @(negedge clk);
        check("l0_store_valid", 32'(b0.rsp_valid), 32'd1);
        check("l0_store_rdata", 32'(b0.rsp_rdata), 32'h0);
        check("l0_store_error", 32'(b0.rsp_error), 32'd0);
        b0.req_write = 1'b0;
        for (int n = 2; n <= 7; n++) begin
            @(negedge clk);
            check($sformatf("l0_b2b_valid_%0d", n), 32'(b0.rsp_valid), 32'(n % 2));
            if (n % 2 == 1) check($sformatf("l0_b2b_rdata_%0d", n), 32'(b0.rsp_rdata), 32'h00A5);
        end
        b0.req_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Wait-state data-memory responder for the multi-cycle processor variant. It serves load/store requests from the datapath over a valid/ready request channel and a valid/ready response channel. It inserts a parameterised number of wait cycles and owns the data storage array. It replaces the zero-latency data memory, so the datapath can be verified against realistic memory timing.

Parameters:
Bits, 16, data word width and request address width
MemSize, 8, number of words in the array (word-addressed)
Latency, 2, wait cycles between request acceptance and response; 0 to 15 legal

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
req_valid  in  1  requester presents a request
req_write  in  1  1 = store, 0 = load
req_addr  in  Bits  word address (datapath ALU result)
req_wdata  in  Bits  store data (rs2 value)
req_ready  out  1  responder can accept a request this cycle
rsp_valid  out  1  response available
rsp_ready  in  1  requester consumes the response
rsp_rdata  out  Bits  load data; 0 for stores and errors
rsp_error  out  1  address was out of range (req_addr >= MemSize)

Behaviour:
- Reset (rst=0, async): state=IDLE; all array words=0; wait counter=0; rsp_valid=0; rsp_rdata=0; rsp_error=0. req_ready=1 once rst deasserts, because it decodes IDLE.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted on a rising edge with req_valid=1.
  - Capture req_write, req_addr, req_wdata into internal registers.
  - If Latency>0, load counter=Latency-1 and go to WAIT.
  - If Latency=0, perform the access at this same edge and go to RESP.
- WAIT: req_ready=0; requests are ignored, not queued. Counter decrements each cycle. When counter=0, perform the access at that edge and go to RESP.
- Access rules:
  - In range, load: rsp_rdata=mem[addr], rsp_error=0.
  - In range, store: mem[addr]=wdata; rsp_rdata=0, rsp_error=0.
  - Out of range: no array change; rsp_rdata=0, rsp_error=1.
  - Address compare uses the full Bits width, unsigned.
- RESP: rsp_valid=1 and req_ready=0. rsp_rdata and rsp_error hold stable until the handshake.
  - On an edge with rsp_ready=1: rsp_valid deasserts next cycle, rsp_rdata and rsp_error clear to 0, go to IDLE.
  - rsp_ready=0 stalls in RESP indefinitely.
- Latency from acceptance edge to rsp_valid high is Latency+1 cycles. Minimum request-to-request spacing is Latency+2 cycles.
- rsp_ready while not in RESP: ignored.
- req_valid changing during WAIT or RESP: ignored. Captured registers are used.
- Reset mid-operation:
  - A store still in WAIT is discarded and never written.
  - A store already committed is lost because the array clears.
  - An in-flight response is dropped; rsp_valid=0 immediately (async).
- Store then load to the same address: the load returns the new data. This holds because a store commits before its response, which precedes the next acceptance.

Decomposition:
- Package dmem_pkg: typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t; localparam CNT_W=4.
- One sub-module, dmem_array: storage only. Synchronous write enable, combinational read, async active-low clear; parameters Bits and MemSize.
- The FSM, counter and capture registers stay in data_mem_responder.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release. Require req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0; a load of addr 3 returns 0.
- Store/load, Latency=2: store addr=5 data=16'hBEEF, rsp_ready=1.
  - rsp_valid rises exactly 3 cycles after acceptance with rsp_error=0 and rsp_rdata=0.
  - A following load of addr 5 returns 16'hBEEF, also 3 cycles after its acceptance.
- Back-pressure: load with rsp_ready=0 for 5 cycles. rsp_valid stays 1 and rsp_rdata stays stable; req_ready=0, and a req_valid pulse with a store to addr 5 data 16'h1111 is ignored. Raise rsp_ready: IDLE next cycle, and mem[5] is still 16'hBEEF.
- Out of range, MemSize=8: store addr=8 data=16'h1234 gives rsp_error=1, rsp_rdata=0. Load addr=16'hFFFF gives rsp_error=1. Loads of addr 0..7 are unchanged.
- Latency=0 build: store addr=1 data=16'h00A5 gives rsp_valid 1 cycle after acceptance. Back-to-back requests are accepted every 2 cycles with rsp_ready held 1.
- Reset mid-WAIT: store addr=2 data=16'h7777, assert rst one cycle after acceptance. rsp_valid stays 0, and after release a load of addr 2 returns 0.
